// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline <-> hazard controller signal bundle
// Purpose: groups the stage addresses/enables the controller observes and the
//   stall/flush/forward controls and event counters it produces.
// Modports: slave  - the hazard controller (observes pipeline, drives controls)
//           master - the pipeline side (drives pipeline state, observes controls)
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       rs1_addr_D;
  logic [4:0]       rs2_addr_D;
  logic [4:0]       rs1_addr_E;
  logic [4:0]       rs2_addr_E;
  logic [4:0]       rd_addr_E;
  logic             rd_wren_E;
  logic [1:0]       wb_sel_E;
  logic [4:0]       rd_addr_M;
  logic             rd_wren_M;
  logic [4:0]       rd_addr_W;
  logic             rd_wren_W;
  logic             mispred_E;
  logic             mem_busy_M;
  logic             StallF;
  logic             StallD;
  logic             FlushD;
  logic             FlushE;
  logic             StallE;
  logic             StallM;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport slave (
    input  rs1_addr_D, rs2_addr_D, rs1_addr_E, rs2_addr_E,
    input  rd_addr_E, rd_wren_E, wb_sel_E,
    input  rd_addr_M, rd_wren_M, rd_addr_W, rd_wren_W,
    input  mispred_E, mem_busy_M,
    output StallF, StallD, FlushD, FlushE, StallE, StallM,
    output ForwardAE, ForwardBE, stall_cnt, flush_cnt
  );

  modport master (
    output rs1_addr_D, rs2_addr_D, rs1_addr_E, rs2_addr_E,
    output rd_addr_E, rd_wren_E, wb_sel_E,
    output rd_addr_M, rd_wren_M, rd_addr_W, rd_wren_W,
    output mispred_E, mem_busy_M,
    input  StallF, StallD, FlushD, FlushE, StallE, StallM,
    input  ForwardAE, ForwardBE, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage pipeline hazard and sequencing controller
// Purpose: load-use bubbles, mispredict redirect flushes, data-memory wait
//   stalls, E-stage operand forwarding, saturating stall/flush event counters.
// Ports: i_clk - rising-edge clock
//        i_rst - synchronous active-high reset
//        hz    - hazard_ctrl_if.slave (pipeline state in, controls/counters out)
module hazard_ctrl #(
  parameter logic [1:0] LOAD_SEL     = 2'b01,
  parameter int         REDIRECT_CYC = 1,
  parameter int         CNT_W        = 32
) (
  input  logic           i_clk,
  input  logic           i_rst,
  hazard_ctrl_if.slave   hz
);

  localparam int RW = (REDIRECT_CYC > 1) ? $clog2(REDIRECT_CYC) : 1;

  typedef enum logic [1:0] {RUN, MEM_WAIT, REDIRECT} state_t;

  state_t           state_q, state_d;
  logic             pend_mis_q, pend_mis_d;
  logic [RW-1:0]    rcnt_q, rcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic load_use;
  logic stall_all;
  logic stall_fd;
  logic flush_d;
  logic flush_e;

  // Forwarding source for one E-stage operand; the younger M result wins over W.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       wren_m,
    input logic [4:0] rd_m,
    input logic       wren_w,
    input logic [4:0] rd_w
  );
    if (wren_m && rd_m != 5'd0 && rd_m == rs) return 2'b10;
    if (wren_w && rd_w != 5'd0 && rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  assign load_use = hz.rd_wren_E && hz.wb_sel_E == LOAD_SEL && hz.rd_addr_E != 5'd0 &&
                    (hz.rd_addr_E == hz.rs1_addr_D || hz.rd_addr_E == hz.rs2_addr_D);

  always_comb begin
    state_d    = state_q;
    pend_mis_d = pend_mis_q;
    rcnt_d     = rcnt_q;
    stall_all  = 1'b0;
    stall_fd   = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    if (!i_rst) begin
      unique case (state_q)
        RUN, MEM_WAIT: begin
          if (hz.mem_busy_M) begin
            // A mispredict seen while memory holds M is replayed on release.
            // pend_mis is always 0 in RUN, so OR-ing covers both entry and hold.
            stall_all  = 1'b1;
            pend_mis_d = pend_mis_q | hz.mispred_E;
            state_d    = MEM_WAIT;
          end else if (hz.mispred_E || pend_mis_q) begin
            flush_d    = 1'b1;
            flush_e    = 1'b1;
            pend_mis_d = 1'b0;
            if (REDIRECT_CYC > 1) begin
              state_d = REDIRECT;
              rcnt_d  = RW'(REDIRECT_CYC - 1);
            end else begin
              state_d = RUN;
            end
          end else begin
            state_d = RUN;
            if (load_use) begin
              stall_fd = 1'b1;
              flush_e  = 1'b1;
            end
          end
        end
        REDIRECT: begin
          if (hz.mem_busy_M) begin
            // Memory wait freezes the redirect window; FlushD stays low.
            stall_all = 1'b1;
          end else if (hz.mispred_E) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            rcnt_d  = RW'(REDIRECT_CYC - 1);
          end else begin
            flush_d = 1'b1;
            if (rcnt_q == RW'(1)) state_d = RUN;
            else                  rcnt_d  = rcnt_q - RW'(1);
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign hz.StallF    = stall_all | stall_fd;
  assign hz.StallD    = stall_all | stall_fd;
  assign hz.StallE    = stall_all;
  assign hz.StallM    = stall_all;
  assign hz.FlushD    = flush_d;
  assign hz.FlushE    = flush_e;
  assign hz.ForwardAE = i_rst ? 2'b00 :
                        fwd_sel(hz.rs1_addr_E, hz.rd_wren_M, hz.rd_addr_M, hz.rd_wren_W, hz.rd_addr_W);
  assign hz.ForwardBE = i_rst ? 2'b00 :
                        fwd_sel(hz.rs2_addr_E, hz.rd_wren_M, hz.rd_addr_M, hz.rd_wren_W, hz.rd_addr_W);
  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hz.StallF && stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (hz.FlushE && flush_cnt_q != {CNT_W{1'b1}}) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= RUN;
      pend_mis_q  <= 1'b0;
      rcnt_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_mis_q  <= pend_mis_d;
      rcnt_q      <= rcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed and randomized check of hazard_ctrl against a reference model
module tb_hazard_ctrl;

  localparam int CNT_W = 4;
  localparam int RCYC  = 3;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  hazard_ctrl #(.LOAD_SEL(2'b01), .REDIRECT_CYC(RCYC), .CNT_W(CNT_W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .hz    (hz)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state
  bit m_waiting;
  bit m_pend;
  int m_left;      // remaining redirect FlushD cycles, 0 when not redirecting
  int m_stalls;
  int m_flushes;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int fwd_ref(input int rs, input bit wm, input int rdm, input bit ww, input int rdw);
    if (wm && rdm != 0 && rdm == rs) return 2;
    if (ww && rdw != 0 && rdw == rs) return 1;
    return 0;
  endfunction

  task automatic idle();
    rst = 1'b0;
    hz.rs1_addr_D = 5'd0; hz.rs2_addr_D = 5'd0;
    hz.rs1_addr_E = 5'd0; hz.rs2_addr_E = 5'd0;
    hz.rd_addr_E = 5'd0; hz.rd_wren_E = 1'b0; hz.wb_sel_E = 2'b00;
    hz.rd_addr_M = 5'd0; hz.rd_wren_M = 1'b0;
    hz.rd_addr_W = 5'd0; hz.rd_wren_W = 1'b0;
    hz.mispred_E = 1'b0; hz.mem_busy_M = 1'b0;
  endtask

  // Inputs are already applied (just after a rising edge); check mid-cycle, then advance.
  task automatic tick();
    bit sf, sd, se, sm, fd, fe, lu, mis_eff;
    int fa, fb;
    #4;
    sf = 0; sd = 0; se = 0; sm = 0; fd = 0; fe = 0; fa = 0; fb = 0;
    if (!rst) begin
      fa = fwd_ref(hz.rs1_addr_E, hz.rd_wren_M, hz.rd_addr_M, hz.rd_wren_W, hz.rd_addr_W);
      fb = fwd_ref(hz.rs2_addr_E, hz.rd_wren_M, hz.rd_addr_M, hz.rd_wren_W, hz.rd_addr_W);
      lu = hz.rd_wren_E && hz.wb_sel_E == 2'b01 && hz.rd_addr_E != 0 &&
           (hz.rd_addr_E == hz.rs1_addr_D || hz.rd_addr_E == hz.rs2_addr_D);
      if (hz.mem_busy_M) begin
        sf = 1; sd = 1; se = 1; sm = 1;
      end else if (m_left > 0) begin
        fd = 1;
        fe = hz.mispred_E;
      end else begin
        mis_eff = hz.mispred_E || (m_waiting && m_pend);
        if (mis_eff) begin
          fd = 1; fe = 1;
        end else if (lu) begin
          sf = 1; sd = 1; fe = 1;
        end
      end
    end
    chk("StallF", 32'(hz.StallF), 32'(sf));
    chk("StallD", 32'(hz.StallD), 32'(sd));
    chk("StallE", 32'(hz.StallE), 32'(se));
    chk("StallM", 32'(hz.StallM), 32'(sm));
    chk("FlushD", 32'(hz.FlushD), 32'(fd));
    chk("FlushE", 32'(hz.FlushE), 32'(fe));
    chk("ForwardAE", 32'(hz.ForwardAE), 32'(fa));
    chk("ForwardBE", 32'(hz.ForwardBE), 32'(fb));
    chk("stall_cnt", 32'(hz.stall_cnt), 32'(m_stalls));
    chk("flush_cnt", 32'(hz.flush_cnt), 32'(m_flushes));
    // advance model to the next cycle
    if (rst) begin
      m_waiting = 0; m_pend = 0; m_left = 0; m_stalls = 0; m_flushes = 0;
    end else begin
      if (sf && m_stalls < MAXC) m_stalls++;
      if (fe && m_flushes < MAXC) m_flushes++;
      if (hz.mem_busy_M) begin
        if (m_left == 0) begin
          m_waiting = 1;
          m_pend = m_pend | hz.mispred_E;
        end
      end else if (m_left > 0) begin
        if (hz.mispred_E) m_left = RCYC - 1;
        else              m_left = m_left - 1;
      end else begin
        if (fd) m_left = RCYC - 1;
        m_waiting = 0;
        m_pend = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    m_waiting = 0; m_pend = 0; m_left = 0; m_stalls = 0; m_flushes = 0;
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    tick();                                   // reset cycle: all controls 0
    idle();

    // load-use bubble, then the load reaches W and forwards to op A
    hz.rd_addr_E = 5'd5; hz.rd_wren_E = 1'b1; hz.wb_sel_E = 2'b01; hz.rs1_addr_D = 5'd5;
    tick();
    idle();
    hz.rs1_addr_E = 5'd5; hz.rd_addr_W = 5'd5; hz.rd_wren_W = 1'b1;
    tick();

    // M beats W; rd=0 in M is never forwarded
    idle();
    hz.rs1_addr_E = 5'd3; hz.rd_addr_M = 5'd3; hz.rd_wren_M = 1'b1;
    hz.rd_addr_W = 5'd3; hz.rd_wren_W = 1'b1;
    tick();
    idle();
    hz.rs1_addr_E = 5'd0; hz.rd_addr_M = 5'd0; hz.rd_wren_M = 1'b1;
    tick();

    // mispredict wins over a simultaneous load-use, then the redirect window
    idle();
    hz.rd_addr_E = 5'd7; hz.rd_wren_E = 1'b1; hz.wb_sel_E = 2'b01; hz.rs2_addr_D = 5'd7;
    hz.mispred_E = 1'b1;
    tick();
    idle();
    repeat (3) tick();

    // 3-cycle memory wait with a mispredict in the middle, replayed on release
    for (int i = 0; i < 3; i++) begin
      idle();
      hz.mem_busy_M = 1'b1;
      hz.mispred_E = (i == 1);
      tick();
    end
    idle();
    repeat (4) tick();

    // reset while waiting with a pending mispredict: no stale flush afterwards
    hz.mem_busy_M = 1'b1; hz.mispred_E = 1'b1;
    tick();
    hz.mispred_E = 1'b0; rst = 1'b1;
    tick();
    idle();
    repeat (2) tick();

    // counter saturation: more than 2^CNT_W-1 load-use stall cycles
    hz.rd_addr_E = 5'd9; hz.rd_wren_E = 1'b1; hz.wb_sel_E = 2'b01; hz.rs1_addr_D = 5'd9;
    repeat (20) tick();
    idle();
    tick();

    // randomized traffic with occasional reset so counters are seen before saturating
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) < 2);
      hz.rs1_addr_D = 5'($urandom_range(0, 7));
      hz.rs2_addr_D = 5'($urandom_range(0, 7));
      hz.rs1_addr_E = 5'($urandom_range(0, 7));
      hz.rs2_addr_E = 5'($urandom_range(0, 7));
      hz.rd_addr_E  = 5'($urandom_range(0, 7));
      hz.rd_wren_E  = ($urandom_range(0, 9) < 7);
      hz.wb_sel_E   = 2'($urandom_range(0, 3));
      hz.rd_addr_M  = 5'($urandom_range(0, 7));
      hz.rd_wren_M  = ($urandom_range(0, 9) < 7);
      hz.rd_addr_W  = 5'($urandom_range(0, 7));
      hz.rd_wren_W  = ($urandom_range(0, 9) < 7);
      hz.mispred_E  = ($urandom_range(0, 99) < 12);
      hz.mem_busy_M = ($urandom_range(0, 99) < 25);
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
